expr_eval: RTL and testbench

Downstream consumer of the single-digit "d(op d)*" expression recognizer. Samples the same 8-bit ASCII character stream and computes the arithmetic value of the expression, with '*' binding tighter than '+'. An '=' character terminates each expression and presents the result with error and overflow flags. Internal state then clears for the next expression.

---
 rtl/expr_pkg.sv | 16 +
 rtl/expr_mac.sv | 23 ++
 rtl/expr_eval.sv | 90 +++++++++
 tb/tb_expr_eval.sv | 145 ++++++++++++++
 4 files changed

// File: rtl/expr_pkg.sv
// expr_pkg: character codes, FSM state encoding and digit test shared by the expression evaluator.
package expr_pkg;
   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;
   localparam logic [7:0] CH_EQ   = 8'h3D;
   localparam logic [2:0] S_IDLE = 3'd0;
   localparam logic [2:0] S_NUM  = 3'd1;
   localparam logic [2:0] S_ADD  = 3'd2;
   localparam logic [2:0] S_MUL  = 3'd3;
   localparam logic [2:0] S_ERR  = 3'd4;
   function automatic logic is_digit(input logic [7:0] c);
      return (c >= CH_0) && (c <= CH_9);
   endfunction
endpackage

// File: rtl/expr_mac.sv
// expr_mac: combinational term*digit or sum+term with overflow detect.
// Define EXPR_SAT_EN to clamp overflowing results to all-ones instead of wrapping.
module expr_mac #(
   parameter int W = 16
) (
   input  logic [W-1:0] term_i,
   input  logic [3:0]   digit_i,
   input  logic [W-1:0] sum_i,
   input  logic         mul_i,
   output logic [W-1:0] res_o,
   output logic         ovf_o
);
   logic [W+3:0] prod;
   logic [W:0]   add;
   assign prod  = term_i * digit_i;
   assign add   = sum_i + term_i;
   assign ovf_o = mul_i ? |prod[W+3:W] : add[W];
`ifdef EXPR_SAT_EN
   assign res_o = ovf_o ? '1 : (mul_i ? prod[W-1:0] : add[W-1:0]);
`else
   assign res_o = mul_i ? prod[W-1:0] : add[W-1:0];
`endif
endmodule

// File: rtl/expr_eval.sv
// expr_eval: evaluates single-digit "d(op d)*" ASCII expressions ('*' before '+'), result on '='.
// Saturating arithmetic is selected with EXPR_SAT_EN (see expr_mac).
module expr_eval
   import expr_pkg::*;
#(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         clr_n,
   input  logic         in_valid,
   input  logic [7:0]   in,
   output logic         acc_ok,
   output logic         res_valid,
   output logic [W-1:0] res,
   output logic         res_err,
   output logic         res_ovf
);
   logic [2:0]   state_q, state_d;
   logic [W-1:0] sum_q, sum_d, term_q, term_d, res_q;
   logic         ovf_q, ovf_d, res_valid_q, res_err_q, res_ovf_q;
   logic [W-1:0] mac_r;
   logic         mac_ovf, dig, eq, num, mul;
   assign dig = is_digit(in);
   assign eq  = in == CH_EQ;
   assign num = state_q == S_NUM;
   assign mul = (state_q == S_MUL) && dig;
   // One shared unit: multiply while folding a digit into a term, otherwise sum+term.
   expr_mac #(.W(W)) u_mac (
      .term_i  (term_q),
      .digit_i (in[3:0]),
      .sum_i   (sum_q),
      .mul_i   (mul),
      .res_o   (mac_r),
      .ovf_o   (mac_ovf)
   );
   always_comb begin
      state_d = state_q;
      sum_d   = sum_q;
      term_d  = term_q;
      ovf_d   = ovf_q;
      if (in_valid) begin
         state_d = eq ? S_IDLE
                 : dig ? ((state_q == S_IDLE || state_q == S_ADD || state_q == S_MUL) ? S_NUM : S_ERR)
                 : (num && in == CH_PLUS) ? S_ADD
                 : (num && in == CH_STAR) ? S_MUL : S_ERR;
         if (eq) begin
            sum_d  = '0;
            term_d = '0;
            ovf_d  = 1'b0;
         end else if (mul) begin
            term_d = mac_r;
            ovf_d  = ovf_q | mac_ovf;
         end else if (dig && (state_q == S_IDLE || state_q == S_ADD)) begin
            term_d = W'(in[3:0]);
         end else if (num && in == CH_PLUS) begin
            sum_d  = mac_r;
            term_d = '0;
            ovf_d  = ovf_q | mac_ovf;
         end
      end
   end
   always_ff @(posedge clk or negedge clr_n) begin
      if (!clr_n) begin
         state_q     <= S_IDLE;
         sum_q       <= '0;
         term_q      <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         res_q       <= '0;
         res_err_q   <= 1'b0;
         res_ovf_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         sum_q       <= sum_d;
         term_q      <= term_d;
         ovf_q       <= ovf_d;
         res_valid_q <= in_valid && eq;
         if (in_valid && eq) begin
            res_q     <= num ? mac_r : '0;
            res_err_q <= !num;
            res_ovf_q <= ovf_q | (num & mac_ovf);
         end
      end
   end
   assign acc_ok    = num;
   assign res_valid = res_valid_q;
   assign res       = res_q;
   assign res_err   = res_err_q;
   assign res_ovf   = res_ovf_q;
endmodule

// File: tb/tb_expr_eval.sv
// tb_expr_eval: directed and random expressions checked against a string-level evaluator.
module tb_expr_eval;
   localparam int W = 8;
   localparam longint MAX = (64'd1 << W) - 1;
`ifdef EXPR_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif
   logic         clk = 1'b0;
   logic         clr_n = 1'b0;
   logic         in_valid = 1'b0;
   logic [7:0]   in_c = 8'h00;
   logic         acc_ok, res_valid, res_err, res_ovf;
   logic [W-1:0] res;
   int           n_chk = 0;
   int           n_err = 0;
   logic [7:0]   expr_q[$];
   longint       last_res = 0;
   bit           last_err = 0, last_ovf = 0, m_ovf;
   expr_eval #(.W(W)) dut (
      .clk       (clk),
      .clr_n     (clr_n),
      .in_valid  (in_valid),
      .in        (in_c),
      .acc_ok    (acc_ok),
      .res_valid (res_valid),
      .res       (res),
      .res_err   (res_err),
      .res_ovf   (res_ovf)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask
   function automatic bit well_formed(input logic [7:0] s[$]);
      if (s.size() % 2 == 0) return 1'b0;
      foreach (s[i])
         if ((i % 2 == 0) ? !(s[i] >= "0" && s[i] <= "9") : !(s[i] == "+" || s[i] == "*")) return 1'b0;
      return 1'b1;
   endfunction
   function automatic longint fold(input longint t);
      if (t > MAX) begin
         m_ovf = 1'b1;
         return SAT ? MAX : (t & MAX);
      end
      return t;
   endfunction
   // Products bind first: each '+' closes a term into the running sum.
   function automatic longint evaluate(input logic [7:0] s[$]);
      longint sum = 0, p = 0, d;
      m_ovf = 1'b0;
      for (int i = 0; i < s.size(); i += 2) begin
         d = longint'(s[i] - 8'h30);
         if (i == 0) p = d;
         else if (s[i-1] == "+") begin
            sum = fold(sum + p);
            p = d;
         end else p = fold(p * d);
      end
      return fold(sum + p);
   endfunction
   task automatic step(input bit v, input logic [7:0] c);
      bit fire;
      in_valid = v;
      in_c = c;
      @(negedge clk);
      fire = v && c == "=";
      if (fire) begin
         last_err = !well_formed(expr_q);
         last_res = last_err ? 0 : evaluate(expr_q);
         last_ovf = m_ovf;
         expr_q.delete();
      end else if (v) expr_q.push_back(c);
      chk("res_valid", res_valid, fire);
      chk("acc_ok", acc_ok, well_formed(expr_q));
      chk("res", res, last_res[31:0]);
      chk("res_err", res_err, last_err);
      if (!last_err) chk("res_ovf", res_ovf, last_ovf);
      in_valid = 1'b0;
   endtask
   task automatic send(input string s);
      for (int i = 0; i < s.len(); i++) step(1'b1, s[i]);
   endtask
   initial begin
      #2;
      chk("rst_acc_ok", acc_ok, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_res", res, 0);
      @(negedge clk);
      clr_n = 1'b1;
      send("3+4*5=");
      chk("dir_23", res, 23);
      send("2*3*4+1=");
      chk("dir_25", res, 25);
      send("7=");
      chk("dir_7", res, 7);
      send("3++4=");
      chk("dir_err", res_err, 1);
      send("8*2=");
      chk("dir_16", res, 16);
      send("9");
      repeat (3) step(1'b0, "9");
      send("*9=");
      chk("dir_81", res, 81);
      send("9*9*9=");
      chk("dir_999", res, SAT ? 255 : 217);
      chk("dir_999_ovf", res_ovf, 1);
      send("=");
      chk("dir_eq_err", res_err, 1);
      send("a");
      send("=");
      send("5*");
      #2 clr_n = 1'b0;
      #1;
      chk("arst_res", res, 0);
      chk("arst_acc_ok", acc_ok, 0);
      chk("arst_res_valid", res_valid, 0);
      expr_q.delete();
      last_res = 0;
      last_err = 0;
      last_ovf = 0;
      @(negedge clk);
      clr_n = 1'b1;
      send("6=");
      chk("dir_6", res, 6);
      for (int e = 0; e < 80; e++) begin
         int n = $urandom_range(1, 5);
         for (int k = 0; k < 2 * n - 1; k++) begin
            logic [7:0] c;
            c = (k % 2 == 0) ? 8'h30 + 8'($urandom_range(0, 9)) : ($urandom_range(0, 1) ? "+" : "*");
            if ($urandom_range(0, 19) == 0) c = ($urandom_range(0, 1) ? "+" : "x");
            if ($urandom_range(0, 5) == 0) step(1'b0, 8'($urandom));
            step(1'b1, c);
         end
         step(1'b1, "=");
      end
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
